// File: rtl/axi_lite_reg_pkg.sv
// Shared register map, STATUS bit positions and CTRL field positions for the
// axi_lite_reg_bank register file.
package axi_lite_reg_pkg;

  localparam int REG_W = 32;

  localparam logic [15:0] ADDR_ID       = 16'h0000;
  localparam logic [15:0] ADDR_CTRL     = 16'h0004;
  localparam logic [15:0] ADDR_STATUS   = 16'h0008;
  localparam logic [15:0] ADDR_TS       = 16'h000C;
  localparam logic [15:0] ADDR_SCRATCH0 = 16'h0010;

  localparam int ST_W      = 3;
  localparam int ST_WR_ERR = 0;
  localparam int ST_RD_ERR = 1;
  localparam int ST_RD_OVR = 2;

  localparam int CTRL_TS_EN    = 0;
  localparam int CTRL_TS_CLR   = 1;
  localparam int CTRL_MASK_LSB = 8;
  localparam int CTRL_MASK_W   = 8;
  localparam int CTRL_OUT_W    = 8;

  typedef enum logic [2:0] {
    REG_ID,
    REG_CTRL,
    REG_STATUS,
    REG_TS,
    REG_SCRATCH,
    REG_NONE
  } reg_sel_e;

  typedef struct packed {
    reg_sel_e   sel;
    logic [3:0] idx;
  } reg_dec_t;

endpackage

// File: rtl/axi_lite_rd_pipe.sv
// Fixed-latency read return pipe: a sampled word enters on push and leaves
// exactly LATENCY cycles later with a one-cycle valid.
module axi_lite_rd_pipe #(
  parameter int DW      = 32,
  parameter int LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  output logic          pop_valid,
  output logic [DW-1:0] pop_data,
  output logic          busy
);

  logic [LATENCY-1:0]         valid_q;
  logic [LATENCY-1:0][DW-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q[0] <= push;
      data_q[0]  <= push ? push_data : '0;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  // The final stage is the finish cycle itself, so a new read may enter then.
  generate
    if (LATENCY == 1) begin : g_single
      assign busy = 1'b0;
    end else begin : g_multi
      assign busy = |valid_q[LATENCY-2:0];
    end
  endgenerate

  assign pop_valid = valid_q[LATENCY-1];
  assign pop_data  = data_q[LATENCY-1];

endmodule

// File: rtl/axi_lite_reg_bank.sv
// Register bank behind the axi_lite_slave CPU-side strobes: ID, CTRL, W1C STATUS,
// free-running TIMESTAMP and scratch words, plus control bits and an interrupt.
module axi_lite_reg_bank
  import axi_lite_reg_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 16,
  parameter int          NUM_SCRATCH        = 4,
  parameter int          READ_LATENCY       = 1,
  parameter logic [31:0] ID_VALUE           = 32'h5A5A_0001
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESET,
  input  logic                          write_req_cpu_to_axi,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] write_addr_cpu_to_axi,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] write_data_cpu_to_axi,
  input  logic                          read_req_cpu_to_axi,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] read_addr_cpu_to_axi,
  output logic [C_S_AXI_DATA_WIDTH-1:0] read_data_axi_to_cpu,
  output logic                          read_finish_axi_to_cpu,
  output logic [CTRL_OUT_W-1:0]         ctrl_out,
  output logic                          irq
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int WW = AW - 2;
  localparam logic [WW-1:0] SCR_BASE = WW'(ADDR_SCRATCH0 >> 2);

  // Handshake: write_req and read_req are single-cycle strobes with no back-
  // pressure. A read is accepted only when no earlier read is still in flight;
  // read_finish then pulses exactly READ_LATENCY cycles later with valid data.

  function automatic reg_dec_t decode(input logic [WW-1:0] word);
    reg_dec_t d;
    d.sel = REG_NONE;
    d.idx = '0;
    if (word == WW'(ADDR_ID >> 2))          d.sel = REG_ID;
    else if (word == WW'(ADDR_CTRL >> 2))   d.sel = REG_CTRL;
    else if (word == WW'(ADDR_STATUS >> 2)) d.sel = REG_STATUS;
    else if (word == WW'(ADDR_TS >> 2))     d.sel = REG_TS;
    else if (word >= SCR_BASE && word < SCR_BASE + WW'(NUM_SCRATCH)) begin
      d.sel = REG_SCRATCH;
      d.idx = 4'(word - SCR_BASE);
    end
    return d;
  endfunction

  logic [DW-1:0]   ctrl_q, ctrl_d;
  logic [ST_W-1:0] status_q, status_d;
  logic [DW-1:0]   ts_q, ts_d;
  logic [DW-1:0]   scratch_q [NUM_SCRATCH];
  logic            irq_q;

  reg_dec_t        wr_dec, rd_dec;
  logic            wr_writable, wr_err, rd_accept, rd_err, rd_ovr, rd_busy;
  logic [ST_W-1:0] st_set, st_clr;
  logic [DW-1:0]   rd_word;
  logic            unused_addr_bits;

  assign wr_dec = decode(write_addr_cpu_to_axi[AW-1:2]);
  assign rd_dec = decode(read_addr_cpu_to_axi[AW-1:2]);
  assign unused_addr_bits = ^{write_addr_cpu_to_axi[1:0], read_addr_cpu_to_axi[1:0]};

  assign wr_writable = (wr_dec.sel == REG_CTRL) || (wr_dec.sel == REG_STATUS) ||
                       (wr_dec.sel == REG_SCRATCH);
  assign wr_err      = write_req_cpu_to_axi && !wr_writable;
  assign rd_accept   = read_req_cpu_to_axi && !rd_busy;
  assign rd_err      = rd_accept && (rd_dec.sel == REG_NONE);
  assign rd_ovr      = read_req_cpu_to_axi && rd_busy;

  always_comb begin
    st_set = '0;
    st_clr = '0;
    st_set[ST_WR_ERR] = wr_err;
    st_set[ST_RD_ERR] = rd_err;
    st_set[ST_RD_OVR] = rd_ovr;
    if (write_req_cpu_to_axi && wr_dec.sel == REG_STATUS)
      st_clr = write_data_cpu_to_axi[ST_W-1:0];
    // Hardware set wins over a software clear in the same cycle.
    status_d = (status_q & ~st_clr) | st_set;
  end

  always_comb begin
    ctrl_d = ctrl_q;
    ctrl_d[CTRL_TS_CLR] = 1'b0;
    if (write_req_cpu_to_axi && wr_dec.sel == REG_CTRL)
      ctrl_d = write_data_cpu_to_axi;
  end

  always_comb begin
    ts_d = ts_q;
    if (write_req_cpu_to_axi && wr_dec.sel == REG_CTRL &&
        write_data_cpu_to_axi[CTRL_TS_CLR])
      ts_d = '0;
    else if (ctrl_q[CTRL_TS_EN])
      ts_d = ts_q + 1'b1;
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      ctrl_q   <= '0;
      status_q <= '0;
      ts_q     <= '0;
      irq_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      status_q <= status_d;
      ts_q     <= ts_d;
      irq_q    <= |(status_q & ctrl_q[CTRL_MASK_LSB +: ST_W]);
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SCRATCH; i++)
        if (write_req_cpu_to_axi && wr_dec.sel == REG_SCRATCH && wr_dec.idx == 4'(i))
          scratch_q[i] <= write_data_cpu_to_axi;
    end
  end

  // Sampled from current register state, so a same-cycle write is not seen.
  always_comb begin
    rd_word = '0;
    case (rd_dec.sel)
      REG_ID:     rd_word = ID_VALUE;
      REG_CTRL: begin
        rd_word = ctrl_q;
        rd_word[CTRL_TS_CLR] = 1'b0;
      end
      REG_STATUS: rd_word = DW'(status_q);
      REG_TS:     rd_word = ts_q;
      REG_SCRATCH: begin
        for (int i = 0; i < NUM_SCRATCH; i++)
          if (rd_dec.idx == 4'(i)) rd_word = scratch_q[i];
      end
      default:    rd_word = '0;
    endcase
  end

  axi_lite_rd_pipe #(
    .DW      (DW),
    .LATENCY (READ_LATENCY)
  ) u_rd_pipe (
    .clk       (S_AXI_ACLK),
    .rst       (S_AXI_ARESET),
    .push      (rd_accept),
    .push_data (rd_word),
    .pop_valid (read_finish_axi_to_cpu),
    .pop_data  (read_data_axi_to_cpu),
    .busy      (rd_busy)
  );

  assign ctrl_out = ctrl_q[CTRL_OUT_W-1:0];
  assign irq      = irq_q;

endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// Directed bench for axi_lite_reg_bank with READ_LATENCY=3: register map,
// timestamp, W1C status, irq, read overrun and reset during a read.
module tb_axi_lite_reg_bank;

  localparam int RL = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_req = 1'b0;
  logic [15:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        rd_req = 1'b0;
  logic [15:0] rd_addr = '0;
  logic [31:0] rd_data;
  logic        rd_fin;
  logic [7:0]  ctrl_out;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  axi_lite_reg_bank #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (16),
    .NUM_SCRATCH        (4),
    .READ_LATENCY       (RL),
    .ID_VALUE           (32'h5A5A_0001)
  ) dut (
    .S_AXI_ACLK             (clk),
    .S_AXI_ARESET           (rst),
    .write_req_cpu_to_axi   (wr_req),
    .write_addr_cpu_to_axi  (wr_addr),
    .write_data_cpu_to_axi  (wr_data),
    .read_req_cpu_to_axi    (rd_req),
    .read_addr_cpu_to_axi   (rd_addr),
    .read_data_axi_to_cpu   (rd_data),
    .read_finish_axi_to_cpu (rd_fin),
    .ctrl_out               (ctrl_out),
    .irq                    (irq)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [15:0] addr, input logic [31:0] data);
    wr_req  = 1'b1;
    wr_addr = addr;
    wr_data = data;
    tick();
    wr_req  = 1'b0;
  endtask

  // Issues a read (optionally with a same-cycle write) and checks the finish
  // timing and data against the scoreboard queue.
  task automatic read_reg(input logic [15:0] addr, input logic [31:0] exp, input string tag,
                          input bit do_wr = 1'b0, input logic [15:0] waddr = '0,
                          input logic [31:0] wdata = '0);
    logic [31:0] want;
    exp_q.push_back(exp);
    rd_req  = 1'b1;
    rd_addr = addr;
    if (do_wr) begin
      wr_req  = 1'b1;
      wr_addr = waddr;
      wr_data = wdata;
    end
    tick();
    rd_req = 1'b0;
    wr_req = 1'b0;
    for (int k = 1; k < RL; k++) begin
      chk({tag, "_early_fin"}, 32'(rd_fin), 32'd0);
      tick();
    end
    want = exp_q.pop_front();
    chk({tag, "_fin"}, 32'(rd_fin), 32'd1);
    chk({tag, "_data"}, rd_data, want);
    tick();
    chk({tag, "_fin_drop"}, 32'(rd_fin), 32'd0);
  endtask

  // Directed sequence
  initial begin
    logic [31:0] want;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_fin", 32'(rd_fin), 32'd0);
    chk("rst_data", rd_data, 32'd0);
    chk("rst_ctrl_out", 32'(ctrl_out), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);

    read_reg(16'h0000, 32'h5A5A_0001, "id");
    read_reg(16'h0003, 32'h5A5A_0001, "id_lowbits");

    write_reg(16'h0010, 32'hCAFE_F00D);
    read_reg(16'h0010, 32'hCAFE_F00D, "scr0");
    read_reg(16'h0014, 32'h0, "scr1_same_cycle", 1'b1, 16'h0014, 32'h1);
    read_reg(16'h0014, 32'h1, "scr1_after");
    read_reg(16'h0010, 32'hCAFE_F00D, "rd_wr_diff", 1'b1, 16'h0018, 32'h1234_5678);
    read_reg(16'h0018, 32'h1234_5678, "scr2");

    // Timestamp: enabled at w+1, counts from w+2, so ten cycles later it reads 10.
    write_reg(16'h0004, 32'h1);
    repeat (10) tick();
    read_reg(16'h000C, 32'd10, "ts_count");
    write_reg(16'h0004, 32'h3);
    read_reg(16'h000C, 32'd0, "ts_clear");
    read_reg(16'h000C, 32'd4, "ts_after_clear");
    read_reg(16'h0004, 32'h1, "ctrl_clr_selfclear");
    chk("ctrl_out_en", 32'(ctrl_out), 32'h1);

    write_reg(16'h0040, 32'hDEAD_BEEF);
    read_reg(16'h0008, 32'h1, "status_wr_unmapped");
    write_reg(16'h0004, 32'h0100);
    chk("irq_before", 32'(irq), 32'd0);
    tick();
    chk("irq_rise", 32'(irq), 32'd1);
    chk("ctrl_out_mask", 32'(ctrl_out), 32'h0);
    write_reg(16'h0008, 32'h1);
    chk("irq_hold", 32'(irq), 32'd1);
    tick();
    chk("irq_fall", 32'(irq), 32'd0);
    read_reg(16'h0008, 32'h0, "status_w1c");

    write_reg(16'h0000, 32'h1111_1111);
    read_reg(16'h0000, 32'h5A5A_0001, "id_ro");
    read_reg(16'h0044, 32'h0, "rd_unmapped_w1c", 1'b1, 16'h0008, 32'h3);
    read_reg(16'h0008, 32'h2, "status_set_wins");
    chk("irq_masked", 32'(irq), 32'd0);
    write_reg(16'h0008, 32'h2);
    read_reg(16'h0008, 32'h0, "status_clear2");

    // Overrun: second read while busy is dropped; first completes at t0+RL.
    exp_q.push_back(32'hCAFE_F00D);
    rd_req  = 1'b1;
    rd_addr = 16'h0010;
    tick();
    rd_addr = 16'h0014;
    chk("ovr_t1_fin", 32'(rd_fin), 32'd0);
    tick();
    rd_req = 1'b0;
    chk("ovr_t2_fin", 32'(rd_fin), 32'd0);
    tick();
    want = exp_q.pop_front();
    chk("ovr_t3_fin", 32'(rd_fin), 32'd1);
    chk("ovr_t3_data", rd_data, want);
    tick();
    chk("ovr_t4_fin", 32'(rd_fin), 32'd0);
    tick();
    chk("ovr_t5_fin", 32'(rd_fin), 32'd0);
    read_reg(16'h0008, 32'h4, "status_ovr");
    write_reg(16'h0008, 32'h4);

    // Reset one cycle into a read: no finish afterwards, registers back to reset.
    write_reg(16'h0004, 32'h0101);
    write_reg(16'h0040, 32'h0);
    tick();
    chk("pre_rst_irq", 32'(irq), 32'd1);
    chk("pre_rst_ctrl_out", 32'(ctrl_out), 32'h1);
    rd_req  = 1'b1;
    rd_addr = 16'h0010;
    tick();
    rd_req = 1'b0;
    rst    = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("rst_mid_no_fin", 32'(rd_fin), 32'd0);
      tick();
    end
    chk("rst_mid_irq", 32'(irq), 32'd0);
    chk("rst_mid_ctrl_out", 32'(ctrl_out), 32'd0);
    read_reg(16'h0004, 32'h0, "rst_ctrl");
    read_reg(16'h0008, 32'h0, "rst_status");
    read_reg(16'h000C, 32'h0, "rst_ts");
    read_reg(16'h0010, 32'h0, "rst_scr0");
    read_reg(16'h0018, 32'h0, "rst_scr2");

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
